// File: rtl/bsr_seq.sv
// -----------------------------------------------------------------------------
// bsr_seq -- sequential barrel-shift-right unit.
//
// Shifts an operand right by N bit positions, one position per clock, using a
// small IDLE -> SHIFT -> DONE state machine. The operand, shift amount and mode
// are captured on the start edge. After that, the inputs may change freely.
// The result appears on o_bsr together with a one-cycle o_done pulse exactly
// N+1 edges after the capture edge.
//
// Parameters
//   WIDTH    data width in bits
//   SA_W     shift-amount width; the largest shift is 2**SA_W-1
//
// Ports
//   i_clk    clock; all state changes on its rising edge
//   i_rst_n  synchronous active-low reset; takes priority over everything
//   i_start  start request; sampled only while o_busy = 0
//   i_b      operand to shift right
//   i_sa     shift amount N (unsigned)
//   i_arith  1 = arithmetic (sign fill), 0 = logical (zero fill)
//   o_busy   high while an operation is in SHIFT or DONE
//   o_done   one-cycle pulse when o_bsr holds a new result
//   o_bsr    registered result; holds its value until the next DONE
// -----------------------------------------------------------------------------
module bsr_seq #(
    parameter int WIDTH = 32,
    parameter int SA_W  = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_b,
    input  logic [SA_W-1:0]  i_sa,
    input  logic             i_arith,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_bsr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;     // operand being shifted
    logic [SA_W-1:0]  count;    // remaining single-bit shifts
    logic             mode;     // captured i_arith

    // The bit shifted in at the top. In arithmetic mode, the top bit of the
    // working register never changes, so it always equals the captured MSB.
    logic fill;
    assign fill = mode & work[WIDTH-1];

    // State, datapath and the registered outputs all share one clocked block.
    // As a result, o_busy and o_done come straight from flops and do not
    // glitch.
    // NOTE: every assignment here is non-blocking. Each register then sees
    // the values from before the edge, no matter where it sits in the block.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            // Reset is checked first. It therefore overrides i_start and any
            // operation in flight. An aborted operation never pulses o_done.
            state  <= IDLE;
            work   <= '0;
            count  <= '0;
            mode   <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_bsr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        work   <= i_b;
                        count  <= i_sa;
                        mode   <= i_arith;
                        o_busy <= 1'b1;
                        state  <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (count != '0) begin
                        work  <= {fill, work[WIDTH-1:1]};
                        count <= count - 1'b1;
                    end else begin
                        // The final edge spent in SHIFT publishes the result.
                        // This gives N shift edges plus one load edge after
                        // capture.
                        o_bsr  <= work;
                        o_done <= 1'b1;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    // Return to IDLE without condition. Dropping o_busy here
                    // means a new i_start is accepted in the very next cycle.
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bsr_seq.sv
// -----------------------------------------------------------------------------
// tb_bsr_seq -- self-checking bench for bsr_seq (WIDTH=32, SA_W=5).
//
// The bench applies a table of directed operations, then hand-written
// sequences for a dropped mid-shift start, reset during an operation, and
// start held during reset. It finishes with random operations checked
// against an arithmetic reference, where the result is b >> N or
// signed(b) >>> N and the latency is N+1 edges.
// -----------------------------------------------------------------------------
module tb_bsr_seq;

    localparam int WIDTH = 32;
    localparam int SA_W  = 5;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_start;
    logic [WIDTH-1:0] i_b;
    logic [SA_W-1:0]  i_sa;
    logic             i_arith;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_bsr;

    bsr_seq #(.WIDTH(WIDTH), .SA_W(SA_W)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .i_b     (i_b),
        .i_sa    (i_sa),
        .i_arith (i_arith),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_bsr   (o_bsr)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference model: the required result, written as plain shift operators.
    function automatic logic [31:0] ref_shift(input logic [31:0] b, input int n, input logic ar);
        logic signed [31:0] sb;
        sb = b;
        return ar ? 32'(sb >>> n) : (b >> n);
    endfunction

    // Runs one operation. The task is entered and left 1 time unit after a
    // rising edge, so successive calls run back-to-back. While the operation
    // is in flight, the inputs are scrambled. lat is the number of edges from
    // the capture edge to the edge that raises o_done, or -1 on timeout. When
    // the task returns, one more edge has passed, so the DUT is back in IDLE.
    task automatic run_op(input logic [31:0] b, input logic [4:0] sa, input logic ar,
                          output logic [31:0] res, output int lat, output logic busy_ok);
        i_b = b; i_sa = sa; i_arith = ar; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        lat = -1;
        busy_ok = o_busy;
        for (int k = 1; k <= 80; k++) begin
            i_b = $urandom; i_sa = 5'($urandom); i_arith = 1'($urandom);
            @(posedge i_clk); #1;
            if (o_done) begin
                lat = k;
                break;
            end
            if (!o_busy) busy_ok = 1'b0;
        end
        res = o_bsr;
        if (!o_busy) busy_ok = 1'b0;
        @(posedge i_clk); #1;
    endtask

    typedef struct {
        logic [31:0] b;
        logic [4:0]  sa;
        logic        ar;
        logic [31:0] exp_bsr;
        int          exp_lat;
    } vec_t;

    vec_t vecs[8];

    logic [31:0] res, res2, b_r, exp_r;
    logic [4:0]  sa_r;
    logic        ar_r, busy_ok;
    int          lat, seen_done;

    initial begin
        vecs[0] = '{32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 5};
        vecs[1] = '{32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 5};
        vecs[2] = '{32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1};
        vecs[3] = '{32'h8000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF, 32};
        vecs[4] = '{32'h8000_0001, 5'd31, 1'b0, 32'h0000_0001, 32};
        vecs[5] = '{32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1};
        vecs[6] = '{32'hF000_0000, 5'd1,  1'b1, 32'hF800_0000, 2};
        vecs[7] = '{32'h7FFF_FFFF, 5'd30, 1'b1, 32'h0000_0001, 31};

        i_rst_n = 1'b0; i_start = 1'b0; i_b = '0; i_sa = '0; i_arith = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_busy", 32'(o_busy), 32'd0);
        check("reset_done", 32'(o_done), 32'd0);
        check("reset_bsr",  o_bsr,       32'd0);
        i_rst_n = 1'b1;

        // Directed table; every entry follows the previous one back-to-back.
        foreach (vecs[i]) begin
            run_op(vecs[i].b, vecs[i].sa, vecs[i].ar, res, lat, busy_ok);
            check($sformatf("vec%0d_bsr", i),  res,          vecs[i].exp_bsr);
            check($sformatf("vec%0d_lat", i),  32'(lat),     32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'd1);
            check($sformatf("vec%0d_idle", i), {30'd0, o_busy, o_done}, 32'd0);
            check($sformatf("vec%0d_hold", i), o_bsr,        vecs[i].exp_bsr);
        end

        // A second start in mid-shift, with a different operand, is dropped.
        i_b = 32'hA5A5_0000; i_sa = 5'd8; i_arith = 1'b0; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        i_b = 32'hFFFF_FFFF; i_sa = 5'd1; i_arith = 1'b1; i_start = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        i_start = 1'b0;
        lat = -1;
        for (int k = 6; k <= 40; k++) begin
            @(posedge i_clk); #1;
            if (o_done) begin lat = k; break; end
        end
        check("midstart_lat", 32'(lat), 32'd9);
        check("midstart_bsr", o_bsr, 32'h00A5_A500);
        seen_done = 0;
        repeat (4) begin
            @(posedge i_clk); #1;
            if (o_busy || o_done) seen_done++;
        end
        check("midstart_not_queued", 32'(seen_done), 32'd0);

        // Reset on the 3rd edge of an i_sa=10 operation (the capture edge is
        // the 1st). The operation aborts: no o_done, and o_bsr is cleared.
        i_b = 32'hDEAD_BEEF; i_sa = 5'd10; i_arith = 1'b1; i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        check("rst_mid_busy", 32'(o_busy), 32'd0);
        check("rst_mid_done", 32'(o_done), 32'd0);
        check("rst_mid_bsr",  o_bsr,       32'd0);
        i_rst_n = 1'b1;
        seen_done = 0;
        repeat (15) begin
            @(posedge i_clk); #1;
            if (o_done || o_busy) seen_done++;
        end
        check("rst_mid_no_done", 32'(seen_done), 32'd0);

        // A start held during reset is not accepted.
        i_rst_n = 1'b0; i_start = 1'b1; i_b = 32'h1; i_sa = 5'd0;
        @(posedge i_clk); #1;
        check("rst_start_busy", 32'(o_busy), 32'd0);
        i_start = 1'b0; i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        check("rst_start_idle", 32'(o_busy), 32'd0);

        // Random operations against the reference model.
        for (int t = 0; t < 200; t++) begin
            b_r  = $urandom;
            sa_r = 5'($urandom);
            ar_r = 1'($urandom);
            if (t % 7 == 0) b_r[31] = 1'b1;
            run_op(b_r, sa_r, ar_r, res, lat, busy_ok);
            exp_r = ref_shift(b_r, int'(sa_r), ar_r);
            check($sformatf("rnd%0d_bsr", t),  res,          exp_r);
            check($sformatf("rnd%0d_lat", t),  32'(lat),     32'(int'(sa_r) + 1));
            check($sformatf("rnd%0d_busy", t), 32'(busy_ok), 32'd1);
            res2 = o_bsr;
            check($sformatf("rnd%0d_hold", t), res2,         exp_r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bsr_seq.md
BSR_SEQ -- requirements
Module: bsr_seq

Interface
REQ-001 SHALL have parameter WIDTH, 32, data width in bits.
REQ-002 SHALL have parameter SA_W, 5, shift-amount width; the maximum shift is 2^SA_W-1.
REQ-003 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port i_start  input  1  request to begin a shift; sampled only when o_busy=0.
REQ-006 SHALL have port i_b  input  WIDTH  operand to shift right.
REQ-007 SHALL have port i_sa  input  SA_W  shift amount N, unsigned.
REQ-008 SHALL have port i_arith  input  1  1=arithmetic (sign fill), 0=logical (zero fill).
REQ-009 SHALL have port o_busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse when o_bsr holds a new result.
REQ-011 SHALL have port o_bsr  output  WIDTH  registered shift-right result.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-013 SHALL, in IDLE with i_start=1, capture i_b into a working register, i_sa into a down-counter and i_arith into a mode flag, then move to SHIFT.
REQ-014 SHALL ignore changes to i_b, i_sa and i_arith after the capture edge.
REQ-015 SHALL, in SHIFT with counter≠0, shift the working register right by exactly one bit per edge and decrement the counter by 1.
REQ-016 SHALL use the captured MSB as the fill bit when the mode flag is 1, and 0 otherwise.
REQ-017 SHALL, in SHIFT with counter=0, load o_bsr from the working register and move to DONE.
REQ-018 SHALL hold o_done=1 for exactly the one cycle spent in DONE, then return unconditionally to IDLE.
REQ-019 SHALL assert o_done exactly N+1 rising edges after the edge that captures i_start; for N=0 this is one edge after capture.
REQ-020 SHALL drive o_busy=1 in SHIFT and DONE and o_busy=0 in IDLE.
REQ-021 SHALL ignore i_start whenever o_busy=1; such a request is dropped, not queued.
REQ-022 SHALL accept i_start in the first IDLE cycle after DONE, so back-to-back operations are possible.
REQ-023 SHALL hold o_bsr stable at the last result until the next DONE entry.
REQ-024 SHALL produce a result equal to i_b >> N (logical) or i_b >>> N (arithmetic) for every N in 0..2^SA_W-1.

Reset
REQ-025 SHALL, when i_rst_n=0 at a rising edge, set state=IDLE, o_busy=0, o_done=0, o_bsr=0, the counter to 0 and the working register to 0.
REQ-026 SHALL let reset take priority over i_start and over any in-progress operation.
REQ-027 SHALL, on reset during SHIFT or DONE, abort the operation with no o_done pulse and no o_bsr update.
REQ-028 SHALL not accept i_start on an edge where i_rst_n=0.

Verification
REQ-029 SHALL cover: logical shift, i_b=0x8000_0000, i_sa=4, i_arith=0 -> o_bsr=0x0800_0000; o_done 5 edges after capture.
REQ-030 SHALL cover: arithmetic shift, same operands with i_arith=1 -> o_bsr=0xF800_0000; o_done 5 edges after capture.
REQ-031 SHALL cover: i_sa=0, i_b=0x1234_5678 -> o_bsr=0x1234_5678; o_done 1 edge after capture.
REQ-032 SHALL cover: i_sa=31, i_b=0x8000_0001, i_arith=1 -> 0xFFFF_FFFF; repeated with i_arith=0 -> 0x0000_0001.
REQ-033 SHALL cover: a second i_start asserted mid-SHIFT with different i_b -> ignored, and the first result is unchanged.
REQ-034 SHALL cover: i_rst_n=0 on the 3rd edge of an i_sa=10 operation -> no o_done; o_bsr=0 and o_busy=0 on the next cycle.
